// File: rtl/sram_4kx32_arbiter.sv
// Shares one 1R/1W synchronous SRAM between a read-only fetch port (M0) and a byte-strobed
// load/store port (M1); M1 partial writes become a read cycle followed by a merge-and-write cycle.
module sram_4kx32_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_W-1:0]     m0_addr,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DATA_W/8-1:0]   m1_be,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [ADDR_W-1:0]     sram_raddr,
    input  logic [DATA_W-1:0]     sram_rd,
    output logic [ADDR_W-1:0]     sram_waddr,
    output logic [DATA_W-1:0]     sram_wd,
    output logic                  sram_wen
);

    localparam int BE_W = DATA_W / 8;

    // state  | meaning
    // IDLE   | normal arbitration;  RMW_WR | merge read data with latched strobes and write back
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_rr_last;
    logic [ADDR_W-1:0]   r_raddr;
    logic [ADDR_W-1:0]   r_rmw_addr;
    logic [BE_W-1:0]     r_rmw_be;
    logic [DATA_W-1:0]   r_rmw_wdata;
    logic                r_m0_rvalid, r_m1_rvalid;

    logic                w_m1_rd, w_m1_full, w_m1_part, w_m1_null, w_m1_needs_rd;
    logic                w_m0_ok, w_gnt0, w_gnt1_rd, w_m1_gnt, w_latch;
    logic                w_wen;
    logic [ADDR_W-1:0]   w_waddr, w_raddr;
    logic [DATA_W-1:0]   w_wd;

    assign w_m1_rd       = m1_req && !m1_we;
    assign w_m1_full     = m1_req && m1_we && (m1_be == {BE_W{1'b1}});
    assign w_m1_null     = m1_req && m1_we && (m1_be == '0);
    assign w_m1_part     = m1_req && m1_we && !w_m1_full && !w_m1_null;
    assign w_m1_needs_rd = w_m1_rd || w_m1_part;

    always_comb begin
        w_state_nxt = r_state;
        w_m0_ok     = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1_rd   = 1'b0;
        w_m1_gnt    = 1'b0;
        w_latch     = 1'b0;
        w_wen       = 1'b0;
        w_waddr     = r_rmw_addr;
        w_wd        = r_rmw_wdata;
        w_raddr     = r_raddr;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    // M0 must not read the word M1 is overwriting this same cycle
                    w_m0_ok   = m0_req && !(w_m1_full && (m0_addr == m1_addr));
                    w_gnt0    = w_m0_ok && (!w_m1_needs_rd || r_rr_last);
                    w_gnt1_rd = w_m1_needs_rd && (!w_m0_ok || !r_rr_last);
                    w_m1_gnt  = w_gnt1_rd || w_m1_full || w_m1_null;
                    if (w_m1_full) begin
                        w_wen   = 1'b1;
                        w_waddr = m1_addr;
                        w_wd    = m1_wdata;
                    end
                    if (w_gnt0) begin
                        w_raddr = m0_addr;
                    end else if (w_gnt1_rd) begin
                        w_raddr = m1_addr;
                    end
                    if (w_gnt1_rd && w_m1_part) begin
                        w_latch     = 1'b1;
                        w_state_nxt = RMW_WR;
                    end
                end
                RMW_WR: begin
                    w_wen   = 1'b1;
                    w_waddr = r_rmw_addr;
                    for (int i = 0; i < BE_W; i++) begin
                        w_wd[8*i +: 8] = r_rmw_be[i] ? r_rmw_wdata[8*i +: 8] : sram_rd[8*i +: 8];
                    end
                    w_gnt0 = m0_req && (m0_addr != r_rmw_addr);
                    if (w_gnt0) begin
                        w_raddr = m0_addr;
                    end
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_last   <= 1'b1;
            r_raddr     <= '0;
            r_rmw_addr  <= '0;
            r_rmw_be    <= '0;
            r_rmw_wdata <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_raddr     <= w_raddr;
            r_m0_rvalid <= w_gnt0;
            // the RMW read phase returns data to the merge path, not to M1
            r_m1_rvalid <= w_gnt1_rd && !m1_we;
            if (w_gnt0) begin
                r_rr_last <= 1'b0;
            end else if (w_gnt1_rd) begin
                r_rr_last <= 1'b1;
            end
            if (w_latch) begin
                r_rmw_addr  <= m1_addr;
                r_rmw_be    <= m1_be;
                r_rmw_wdata <= m1_wdata;
            end
        end
    end

    assign m0_gnt     = w_gnt0;
    assign m1_gnt     = w_m1_gnt;
    assign m0_rvalid  = r_m0_rvalid && !rst;
    assign m1_rvalid  = r_m1_rvalid && !rst;
    assign m0_rdata   = sram_rd;
    assign m1_rdata   = sram_rd;
    assign sram_raddr = w_raddr;
    assign sram_waddr = w_waddr;
    assign sram_wd    = w_wd;
    assign sram_wen   = w_wen;

endmodule
